// File: rtl/spm_seq_pkg.sv
// rtl/spm_seq_pkg.sv - shared types and sizing helpers for the spm operand sequencer
package spm_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        SHIFT = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

    function automatic int prod_w(input int width);
        return 2 * width;
    endfunction

    // Wide enough to count a full shift window plus the array pipeline without wrapping.
    function automatic int cnt_w(input int width, input int pipe_lat);
        return $clog2(2 * width + pipe_lat + 1);
    endfunction

endpackage

// File: rtl/spm_serial_seq_if.sv
// rtl/spm_serial_seq_if.sv - operand/product handshakes and serial array links of the spm sequencer
interface spm_serial_seq_if #(
    parameter int WIDTH = 32
);

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_x;
    logic [WIDTH-1:0]     in_y;
    logic [WIDTH-1:0]     x_par;
    logic                 y_ser;
    logic                 arr_clr;
    logic                 p_ser;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_p;

    modport slave (
        input  in_valid, in_x, in_y, p_ser, out_ready,
        output in_ready, x_par, y_ser, arr_clr, out_valid, out_p
    );

    modport master (
        output in_valid, in_x, in_y, p_ser, out_ready,
        input  in_ready, x_par, y_ser, arr_clr, out_valid, out_p
    );

endinterface

// File: rtl/spm_pcollect.sv
// rtl/spm_pcollect.sv - serial-to-parallel collector for the product stream returned by the array
module spm_pcollect
    import spm_seq_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int PIPE_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic                 p_ser_i,
    output logic [2*WIDTH-1:0]   p_o
);

    localparam int PW = prod_w(WIDTH);
    localparam int CW = cnt_w(WIDTH, PIPE_LAT);
    localparam logic [CW-1:0] CNT_MAX = CW'(PW + PIPE_LAT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] p_q, p_d;
    logic          cap;

    // Before PIPE_LAT the subtraction wraps high, so one compare bounds both ends of the window.
    always_comb begin
        cnt_d = cnt_q;
        p_d   = p_q;
        cap   = en_i && ((cnt_q - CW'(PIPE_LAT)) < CW'(PW));
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (cap) begin
            p_d = {p_ser_i, p_q[PW-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            p_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            p_q   <= p_d;
        end
    end

    assign p_o = p_q;

endmodule

// File: rtl/spm_serial_seq.sv
// rtl/spm_serial_seq.sv - operand sequencer and product collector around the spm serial-parallel array
module spm_serial_seq
    import spm_seq_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int PIPE_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    spm_serial_seq_if.slave   bus
);

    localparam int PW = prod_w(WIDTH);
    localparam int CW = cnt_w(WIDTH, PIPE_LAT);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_sr_q, y_sr_d;
    logic             shifting;
    logic [PW-1:0]    prod;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_sr_d  = y_sr_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    x_d     = bus.in_x;
                    y_sr_d  = bus.in_y;
                    cnt_d   = '0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                // Arithmetic shift: once the data bits are gone y_sr[0] keeps presenting the sign.
                y_sr_d = {y_sr_q[WIDTH-1], y_sr_q[WIDTH-1:1]};
                if (cnt_q == CW'(PW - 1)) begin
                    cnt_d = '0;
                    if (PIPE_LAT == 0) begin
                        state_d = DONE;
                    end else begin
                        state_d = DRAIN;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                y_sr_d = {y_sr_q[WIDTH-1], y_sr_q[WIDTH-1:1]};
                if (cnt_q == CW'(PIPE_LAT - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_sr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_sr_q  <= y_sr_d;
        end
    end

    assign shifting      = (state_q == SHIFT) || (state_q == DRAIN);
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.arr_clr   = (state_q == CLEAR);
    assign bus.y_ser     = shifting & y_sr_q[0];
    assign bus.x_par     = x_q;
    assign bus.out_p     = prod;

    spm_pcollect #(
        .WIDTH    (WIDTH),
        .PIPE_LAT (PIPE_LAT)
    ) u_pcollect (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (state_q == CLEAR),
        .en_i    (shifting),
        .p_ser_i (bus.p_ser),
        .p_o     (prod)
    );

endmodule

// File: tb/tb_spm_serial_seq.sv
// tb/tb_spm_serial_seq.sv - self-checking bench for spm_serial_seq with a bit-accurate serial array model
module tb_spm_serial_seq;

    localparam int W      = 8;
    localparam int PL     = 1;
    localparam int PW     = 2 * W;
    localparam int LAT    = 1 + PW + PL;
    localparam int PERIOD = LAT + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    spm_serial_seq_if #(.WIDTH(W)) bus ();

    spm_serial_seq #(
        .WIDTH    (W),
        .PIPE_LAT (PL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    int            last_acc = 0;
    logic          prev_ov = 1'b0;
    logic          prev_acc_b2b = 1'b0;
    logic          b2b = 1'b0;
    logic [PW-1:0] sb[$];

    // Serial-parallel array: accumulate x per serial y bit, emit the LSB one cycle later.
    longint acc_q;
    longint addend;
    logic   p_q;

    assign addend    = bus.y_ser ? longint'($signed(bus.x_par)) : 64'sd0;
    assign bus.p_ser = p_q;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= 0;
            p_q   <= 1'b0;
        end else if (bus.arr_clr) begin
            acc_q <= 0;
            p_q   <= 1'b0;
        end else begin
            p_q   <= acc_q[0] ^ addend[0];
            acc_q <= (acc_q + addend) >>> 1;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
            prev_ov <= 1'b0;
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(PW'(longint'($signed(bus.in_x)) * longint'($signed(bus.in_y))));
                if (b2b && prev_acc_b2b) check("b2b_period", 64'(cyc + 1 - last_acc), 64'(PERIOD));
                last_acc     <= cyc + 1;
                prev_acc_b2b <= b2b;
            end
            if (bus.out_valid && !prev_ov) check("valid_latency", 64'(cyc - last_acc), 64'(LAT));
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) check("sb_underflow", 64'(sb.size()), 64'(1));
                else check("sb_product", 64'(bus.out_p), 64'(sb.pop_front()));
            end
            prev_ov <= bus.out_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check(tag, 64'({bus.in_ready, bus.out_valid, bus.y_ser, bus.arr_clr}), 64'(4'b1000));
        check("rst_x_par", 64'(bus.x_par), 64'(0));
        check("rst_out_p", 64'(bus.out_p), 64'(0));
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 4 * PW && !bus.out_valid; i++) tick();
        check(tag, 64'(bus.out_valid), 64'(1));
    endtask

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [PW-1:0] expc, input bit chk_y);
        logic [PW-1:0] ysx;
        ysx = PW'($signed(y));
        bus.in_x      = x;
        bus.in_y      = y;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("clear_cycle", 64'({bus.arr_clr, bus.y_ser, bus.in_ready}), 64'(3'b100));
        check("x_par_hold", 64'(bus.x_par), 64'(x));
        if (chk_y) begin
            for (int k = 0; k < PW; k++) begin
                tick();
                check("y_ser_bit", 64'(bus.y_ser), 64'(ysx[k]));
            end
        end
        wait_valid("done_timeout");
        check("prod_const", 64'(bus.out_p), 64'(expc));
        tick();
        check("back_idle", 64'({bus.in_ready, bus.out_valid}), 64'(2'b10));
    endtask

    initial begin
        logic [W-1:0] bx[4];
        logic [W-1:0] by[4];
        logic         was_ready;
        int           idx;

        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.out_ready = 1'b0;
        #2 rst = 1'b0;
        #1 check_reset("rst_initial");
        tick();
        tick();
        rst = 1'b1;
        tick();

        do_op(8'd3, 8'd5, 16'h000F, 1'b0);
        do_op(-8'sd3, 8'd5, 16'hFFF1, 1'b0);
        do_op(8'd5, -8'sd3, 16'hFFF1, 1'b1);
        do_op(8'h80, 8'h80, 16'h4000, 1'b0);
        do_op(8'd127, 8'h80, 16'hC080, 1'b0);

        // Backpressure: DONE held while busy-time in_valid pulses must be ignored.
        bus.in_x      = 8'd11;
        bus.in_y      = 8'd13;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        wait_valid("bp_timeout");
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = i[0];
            bus.in_x     = W'($urandom);
            bus.in_y     = W'($urandom);
            tick();
            check("bp_out_p", 64'(bus.out_p), 64'(16'd143));
            check("bp_flags", 64'({bus.in_ready, bus.out_valid, bus.y_ser}), 64'(3'b010));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("bp_release", 64'({bus.in_ready, bus.out_valid}), 64'(2'b10));

        // Reset asserted in SHIFT cycle 5.
        bus.in_x     = 8'd9;
        bus.in_y     = 8'h2F;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (6) tick();
        check("shift5_y_ser", 64'(bus.y_ser), 64'(1));
        #2 rst = 1'b0;
        #1 check_reset("rst_midop");
        tick();
        tick();
        check_reset("rst_held");
        rst = 1'b1;
        tick();
        do_op(8'd2, 8'd7, 16'h000E, 1'b1);

        // Back-to-back with in_valid held high.
        for (int i = 0; i < 4; i++) begin
            bx[i] = W'($urandom);
            by[i] = W'($urandom);
        end
        b2b           = 1'b1;
        idx           = 0;
        bus.out_ready = 1'b1;
        bus.in_x      = bx[0];
        bus.in_y      = by[0];
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 6 * PERIOD && idx < 4; i++) begin
            was_ready = bus.in_ready;
            tick();
            if (was_ready) begin
                idx++;
                if (idx < 4) begin
                    bus.in_x = bx[idx];
                    bus.in_y = by[idx];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        check("b2b_accepts", 64'(idx), 64'(4));
        wait_valid("b2b_timeout");
        tick();
        b2b = 1'b0;
        check("sb_drained", 64'(sb.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before the summary");
        $fatal(1, "watchdog");
    end

endmodule
